reg_file_dumper: RTL and testbench

- Read-side initiator for the CPU register file: walks an inclusive range of register indices on the file's combinational read port and streams each (index, value) pair out over a valid/ready handshake.
- Used by the testbench and debug logic to dump architectural state at end of simulation. It is the counterpart of the file's load-at-init path.
- Drives only a read address; never writes the file.

---
 rtl/reg_file_dumper_pkg.sv | 12 +
 rtl/reg_file_dumper.sv | 102 ++++++++++
 tb/tb_reg_file_dumper.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/reg_file_dumper_pkg.sv
// Shared constants for the register-file dump initiator: FSM encodings and the zero word.
package reg_file_dumper_pkg;

    localparam logic [31:0] WORD_ZERO = 32'h0000_0000;

    localparam logic [2:0] REG_DUMP_IDLE    = 3'd0;
    localparam logic [2:0] REG_DUMP_ADDR    = 3'd1;
    localparam logic [2:0] REG_DUMP_WAIT    = 3'd2;
    localparam logic [2:0] REG_DUMP_PRESENT = 3'd3;
    localparam logic [2:0] REG_DUMP_FINISH  = 3'd4;

endpackage

// File: rtl/reg_file_dumper.sv
// Walks an inclusive (wrapping) range of register indices on a combinational read port and
// streams (index, value) pairs over valid/ready. Define REG_DUMP_SKIP_ZERO_EN to drop zero words.
module reg_file_dumper
    import reg_file_dumper_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_reg,
    input  logic [ADDR_W-1:0] last_reg,
    output logic [ADDR_W-1:0] read_reg,
    input  logic [DATA_W-1:0] read_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_index,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = (READ_LAT > 2) ? $clog2(READ_LAT) : 1;

    logic [2:0]        state;
    logic [ADDR_W-1:0] cur;
    logic [ADDR_W-1:0] last_idx;
    logic [CNT_W-1:0]  wait_cnt;
    logic              skip;
    logic              advance;

`ifdef REG_DUMP_SKIP_ZERO_EN
    // A zero word is consumed on the entry cycle without ever raising out_valid.
    assign skip = (state == REG_DUMP_PRESENT) && !out_valid && (read_data == '0);
`else
    assign skip = 1'b0;
`endif

    assign advance = (state == REG_DUMP_PRESENT) && ((out_valid && out_ready) || skip);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= REG_DUMP_IDLE;
            cur       <= '0;
            last_idx  <= '0;
            wait_cnt  <= '0;
            read_reg  <= '0;
            out_valid <= 1'b0;
            out_index <= '0;
            out_data  <= DATA_W'(WORD_ZERO);
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                REG_DUMP_IDLE: begin
                    if (start) begin
                        cur      <= first_reg;
                        last_idx <= last_reg;
                        busy     <= 1'b1;
                        state    <= REG_DUMP_ADDR;
                    end
                end
                REG_DUMP_ADDR: begin
                    read_reg <= cur;
                    wait_cnt <= CNT_W'(READ_LAT - 1);
                    state    <= (READ_LAT == 1) ? REG_DUMP_PRESENT : REG_DUMP_WAIT;
                end
                REG_DUMP_WAIT: begin
                    // Leave as the counter reaches zero so read_data is sampled READ_LAT cycles on.
                    wait_cnt <= wait_cnt - 1'b1;
                    if (wait_cnt <= CNT_W'(1))
                        state <= REG_DUMP_PRESENT;
                end
                REG_DUMP_PRESENT: begin
                    if (advance) begin
                        out_valid <= 1'b0;
                        if (cur == last_idx) begin
                            done  <= 1'b1;
                            state <= REG_DUMP_FINISH;
                        end else begin
                            cur   <= cur + 1'b1;
                            state <= REG_DUMP_ADDR;
                        end
                    end else if (!out_valid) begin
                        out_valid <= 1'b1;
                        out_index <= cur;
                        out_data  <= read_data;
                    end
                end
                REG_DUMP_FINISH: begin
                    busy  <= 1'b0;
                    state <= REG_DUMP_IDLE;
                end
                default: state <= REG_DUMP_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_file_dumper.sv
// Scoreboard bench for reg_file_dumper against a behavioural 32x32 register file.
module tb_reg_file_dumper;

`ifdef REG_DUMP_SKIP_ZERO_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [4:0]  first_reg = '0;
    logic [4:0]  last_reg = '0;
    logic [4:0]  read_reg;
    logic [31:0] read_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [4:0]  out_index;
    logic [31:0] out_data;
    logic        busy;
    logic        done;

    logic [31:0] rf [32];
    logic [36:0] sb [$];
    int errors = 0;
    int checks = 0;
    int done_cnt = 0;

    assign read_data = rf[read_reg];

    reg_file_dumper #(.DATA_W(32), .ADDR_W(5), .READ_LAT(1)) dut (
        .clk(clk), .rst(rst), .start(start), .first_reg(first_reg), .last_reg(last_reg),
        .read_reg(read_reg), .read_data(read_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_index(out_index), .out_data(out_data), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Handshake completes on the next rising edge; compare against the scoreboard head.
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("extra_entry", {59'd0, out_index}, 64'hFFFF);
            end else begin
                logic [36:0] e;
                e = sb.pop_front();
                chk("entry_idx", 64'(out_index), 64'(e[36:32]));
                chk("entry_data", 64'(out_data), 64'(e[31:0]));
            end
        end
    end

    task automatic push_range(input int f, input int l);
        logic [4:0] i;
        i = 5'(f);
        forever begin
            if (!SKIP || rf[i] != 32'd0) sb.push_back({i, rf[i]});
            if (i == 5'(l)) break;
            i = i + 5'd1;
        end
    endtask

    task automatic drive_start(input int f, input int l);
        @(posedge clk); #1;
        first_reg = 5'(f);
        last_reg  = 5'(l);
        start     = 1'b1;
        push_range(f, l);
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_on", 64'(busy), 64'd1);
    endtask

    task automatic wait_done(input string tag, input int d0);
        int n;
        n = 0;
        while (!done && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            chk({tag, "_timeout"}, 64'd0, 64'd1);
            return;
        end
        chk({tag, "_busy_at_done"}, 64'(busy), 64'd1);
        @(negedge clk);
        chk({tag, "_done_single"}, 64'(done), 64'd0);
        chk({tag, "_busy_fall"}, 64'(busy), 64'd0);
        @(negedge clk);
        chk({tag, "_done_count"}, 64'(done_cnt - d0), 64'd1);
        chk({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int n;
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;
        rf[1]  = 32'h0000_FFFF;
        rf[30] = 32'hFFFF_0000;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_read_reg", 64'(read_reg), 64'd0);
        chk("rst_out_index", 64'(out_index), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        rst = 1'b0;

        // Full range 0..31.
        d0 = done_cnt;
        drive_start(0, 31);
        wait_done("full", d0);

        // Wrapping range with latency check and an ignored mid-dump start.
        d0 = done_cnt;
        drive_start(30, 1);
        @(posedge clk); #1;
        chk("lat_e1", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        chk("lat_e2", 64'(out_valid), 64'd1);
        chk("lat_idx", 64'(out_index), 64'd30);
        first_reg = 5'd10;
        last_reg  = 5'd12;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("wrap", d0);

        // Single-entry range.
        d0 = done_cnt;
        drive_start(5, 5);
        wait_done("single", d0);

        // Backpressure: drop ready after index 1 is accepted, hold the next entry.
        d0 = done_cnt;
        drive_start(0, 31);
        n = 0;
        while (!(out_valid && out_index == 5'd1) && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        chk("bp_saw_idx1", 64'(out_valid && out_index == 5'd1), 64'd1);
        @(posedge clk); #1;
        out_ready = 1'b0;
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("bp_valid", 64'(out_valid), 64'd1);
            if (sb.size() > 0) begin
                chk("bp_idx", 64'(out_index), 64'(sb[0][36:32]));
                chk("bp_data", 64'(out_data), 64'(sb[0][31:0]));
            end else begin
                chk("bp_sb_nonempty", 64'd0, 64'd1);
            end
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_done("bp", d0);

        // Reset two cycles into a dump aborts with no done; then restart fresh.
        rf[8] = 32'h1234_5678;
        d0 = done_cnt;
        drive_start(0, 31);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_valid", 64'(out_valid), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_read_reg", 64'(read_reg), 64'd0);
        sb.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
        chk("abort_idle_busy", 64'(busy), 64'd0);
        d0 = done_cnt;
        drive_start(7, 9);
        wait_done("restart", d0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
